// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EX stage (DIV/DIVU). It produces {remainder, quotient}
// for HI/LO and asks EX to stall while a division is in flight.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   start_i, annul_i       divide request (held until ready_o) / flush abort
//   signed_i               1 = DIV, 0 = DIVU; sampled with start_i
//   opdata1_i, opdata2_i   dividend / divisor; sampled with start_i
//   result_o               {remainder, quotient}; valid while ready_o is high
//   ready_o                registered result-valid flag
//   stallreq_o             start_i & ~ready_o
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_d;
    logic                ready_d;

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   rem_step, quo_step;
    logic [DATA_W-1:0]   rem_fix, quo_fix;

    assign stallreq_o = start_i & ~ready_o;

    assign a_neg = signed_i & opdata1_i[DATA_W-1];
    assign b_neg = signed_i & opdata2_i[DATA_W-1];
    assign a_mag = a_neg ? -opdata1_i : opdata1_i;
    assign b_mag = b_neg ? -opdata2_i : opdata2_i;

    // The quotient register starts out holding the dividend magnitude; its MSB is
    // shifted into the partial remainder while quotient bits fill in from the bottom.
    assign trial = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvsr_q};

    always_comb begin
        rem_step = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
        quo_step = {quo_q[DATA_W-2:0], 1'b0};
        if (!trial[DATA_W]) begin
            rem_step = trial[DATA_W-1:0];
            quo_step = {quo_q[DATA_W-2:0], 1'b1};
        end
    end

    // Negating the most negative quotient wraps to itself, which is the
    // intended result for the overflow case.
    assign quo_fix = neg_quo_q ? -quo_step : quo_step;
    assign rem_fix = neg_rem_q ? -rem_step : rem_step;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_o;
        ready_d   = ready_o;

        unique case (state_q)
            IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvsr_d  = b_mag;
                        state_d = RUN;
                    end
                end
            end
            BYZERO: begin
                // Two cycles here so divide-by-zero reports two edges after start.
                if (annul_i) begin
                    state_d = IDLE;
                end else if (cnt_q == ONE) begin
                    state_d  = DONE;
                    result_d = '0;
                    ready_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            RUN: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (annul_i || !start_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase

        // Leaving via annul never delivers a result.
        if (state_d == IDLE) begin
            result_d = '0;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_o  <= result_d;
            ready_o   <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed and random divides against a
// magnitude-based reference model, with latency, stall, annul and reset checks.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int fails  = 0;
    logic [63:0] sb[$];

    div_seq #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic na, nb;
        logic [31:0] ua, ub, q, r;
        if (b == 32'd0) return 64'd0;
        na = s & a[31];
        nb = s & b[31];
        ua = na ? (~a + 32'd1) : a;
        ub = nb ? (~b + 32'd1) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (na ^ nb) q = ~q + 32'd1;
        if (na) r = ~r + 32'd1;
        return {r, q};
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int lat, input string name);
        int n;
        bit got;
        bit stall_bad;
        logic [63:0] e;
        sb.push_back(exp);
        @(negedge clk);
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin
            fails++;
            $display("FAIL %s stall_at_start: got %b want 1", name, stallreq_o);
        end
        @(posedge clk);
        @(negedge clk);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~s;
        n = 0;
        got = 0;
        stall_bad = 0;
        while (!got && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o === 1'b1) got = 1;
            else if (stallreq_o !== 1'b1) stall_bad = 1;
        end
        e = sb.pop_front();
        checks++;
        if (stall_bad) begin
            fails++;
            $display("FAIL %s stall_in_flight: stallreq dropped before ready", name);
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL %s timeout: no ready within %0d edges", name, n);
            return;
        end
        checks++;
        if (n !== lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        checks++;
        if (result_o !== e) begin
            fails++;
            $display("FAIL %s result: got %h want %h", name, result_o, e);
        end
        checks++;
        if (stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL %s stall_at_ready: got %b want 0", name, stallreq_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || result_o !== e) begin
            fails++;
            $display("FAIL %s hold: ready %b result %h want 1 %h", name, ready_o, result_o, e);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL %s release: ready %b result %h want 0 0", name, ready_o, result_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b1;
        annul_i = 1'b0;
        signed_i = 1'b0;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b1) begin
            fails++;
            $display("FAIL reset: ready %b result %h stall %b want 0 0 1",
                     ready_o, result_o, stallreq_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_stall_idle: got %b want 0", stallreq_o);
        end
    endtask

    task automatic test_divu();
        do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 32, "divu_100_7");
        do_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 32, "divu_max_1");
    endtask

    task automatic test_signed();
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, "div_m7_2");
        do_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 32, "div_7_m2");
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 32, "div_ovf");
        do_div(32'hFFFFFFF9, 32'd2, 1'b0, {32'd1, 32'h7FFFFFFC}, 32, "divu_big_2");
    endtask

    task automatic test_byzero();
        do_div(32'd123, 32'd0, 1'b0, 64'd0, 2, "divu_by0");
        do_div(32'hFFFFFF00, 32'd0, 1'b1, 64'd0, 2, "div_by0");
    endtask

    task automatic test_annul_run();
        bit seen;
        @(negedge clk);
        signed_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL annul_run_edge: ready %b result %h want 0 0", ready_o, result_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL annul_run_silent: ready rose after annul, want never");
        end
        do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 32, "divu_9_3_after_annul");
    endtask

    task automatic test_annul_idle();
        bit seen;
        int n;
        @(negedge clk);
        signed_i = 1'b0;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i = 1'b1;
        annul_i = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL annul_idle: ready rose while annul held, want 0");
        end
        sb.push_back(64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        @(posedge clk);
        n = 0;
        while (ready_o !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL annul_idle_release_latency: got %0d want 2", n);
        end
        checks++;
        if (result_o !== sb.pop_front()) begin
            fails++;
            $display("FAIL annul_idle_result: got %h want 0", result_o);
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL annul_done: ready %b result %h want 0 0", ready_o, result_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_start_drop();
        int n;
        sb.push_back(model(32'd50, 32'd5, 1'b0));
        @(negedge clk);
        signed_i = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL drop_stall: got %b want 0", stallreq_o);
        end
        n = 5;
        while (ready_o !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 32 || result_o !== sb.pop_front()) begin
            fails++;
            $display("FAIL drop_result: edge %0d result %h want 32 %h",
                     n, result_o, {32'd0, 32'd10});
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL drop_pulse: ready %b result %h want 0 0", ready_o, result_o);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        signed_i = 1'b0;
        opdata1_i = 32'd123;
        opdata2_i = 32'd4;
        start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL rst_mid_run: ready %b result %h want 0 0", ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL rst_idle: ready %b result %h want 0 0", ready_o, result_o);
        end
        do_div(32'd123, 32'd4, 1'b0, {32'd3, 32'd30}, 32, "divu_after_rst");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            s = 1'(i % 2);
            do_div(a, b, s, model(a, b, s), (b == 32'd0) ? 2 : 32, "random");
        end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_byzero();
        test_annul_run();
        test_annul_idle();
        test_start_drop();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
